// File: rtl/pc_unit.sv
// pc_unit: IF-stage program counter with stall, redirect and a circular return-address stack
module pc_unit #(
    parameter int ADDR_W = 13,
    parameter int STEP = 1,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter int RAS_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             stall,
    input  logic                             redirect_valid,
    input  logic [ADDR_W-1:0]                redirect_addr,
    input  logic                             call_valid,
    input  logic [ADDR_W-1:0]                call_addr,
    input  logic                             ret_valid,
    output logic [ADDR_W-1:0]                pc,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_overflow,
    output logic                             ras_underflow
);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam int PW = RAS_DEPTH > 1 ? $clog2(RAS_DEPTH) : 1;

    logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
    logic [ADDR_W-1:0] r_pc;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     r_wp;
    logic              r_ovf;
    logic              r_unf;

    logic [ADDR_W-1:0] w_seq, w_pc_nxt;
    logic [CW-1:0]     w_count_nxt;
    logic [PW-1:0]     w_wp_inc, w_wp_dec, w_wp_nxt, w_waddr;
    logic              w_act, w_call, w_ret, w_empty, w_full, w_push, w_pop, w_tail;

    assign w_seq    = r_pc + ADDR_W'(STEP);
    assign w_wp_inc = (r_wp == PW'(RAS_DEPTH - 1)) ? '0 : r_wp + PW'(1);
    assign w_wp_dec = (r_wp == '0) ? PW'(RAS_DEPTH - 1) : r_wp - PW'(1);
    assign w_empty  = r_count == '0;
    assign w_full   = r_count == CW'(RAS_DEPTH);
    assign w_act    = !redirect_valid && !stall;
    assign w_call   = w_act && call_valid;
    assign w_ret    = w_act && ret_valid;
    // a tail call on an empty stack behaves as a plain push
    assign w_tail   = w_call && ret_valid && !w_empty;
    assign w_push   = w_call && !w_tail;
    assign w_pop    = w_ret && !call_valid && !w_empty;
    assign w_waddr  = w_tail ? w_wp_dec : r_wp;

    always_comb begin
        w_pc_nxt    = redirect_valid ? redirect_addr :
                      stall          ? r_pc :
                      call_valid     ? call_addr :
                      ret_valid      ? (w_empty ? w_seq : r_ras[w_wp_dec]) : w_seq;
        w_wp_nxt    = w_push ? w_wp_inc : w_pop ? w_wp_dec : r_wp;
        w_count_nxt = (w_push && !w_full) ? r_count + CW'(1) :
                      w_pop               ? r_count - CW'(1) : r_count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_ADDR;
            r_count <= '0;
            r_wp    <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_count <= w_count_nxt;
            r_wp    <= w_wp_nxt;
            r_ovf   <= w_call && !ret_valid && w_full;
            r_unf   <= w_ret && !call_valid && w_empty;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_call)
            r_ras[w_waddr] <= w_seq;
    end

    assign pc            = r_pc;
    assign ras_count     = r_count;
    assign ras_overflow  = r_ovf;
    assign ras_underflow = r_unf;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: randomized and directed scoreboard bench for pc_unit against a queue-based return-stack model
module tb_pc_unit;
    localparam int AW = 13;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          stall = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_addr = '0;
    logic          call_valid = 1'b0;
    logic [AW-1:0] call_addr = '0;
    logic          ret_valid = 1'b0;
    logic [AW-1:0] pc;
    logic [2:0]    ras_count;
    logic          ras_overflow;
    logic          ras_underflow;

    pc_unit #(.ADDR_W(AW), .STEP(1), .RESET_ADDR('0), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .call_valid(call_valid), .call_addr(call_addr), .ret_valid(ret_valid),
        .pc(pc), .ras_count(ras_count),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] pc;
        int            cnt;
        logic          ovf;
        logic          unf;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_ras[$];
    int            errors = 0;
    int            checks = 0;

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("pc", int'(pc), int'(e.pc));
            check("ras_count", int'(ras_count), e.cnt);
            check("ras_overflow", int'(ras_overflow), int'(e.ovf));
            check("ras_underflow", int'(ras_underflow), int'(e.unf));
        end
    end

    task automatic step(input logic r, input logic rd, input logic [AW-1:0] ra,
                        input logic st, input logic c, input logic [AW-1:0] ca, input logic rt);
        exp_t          e;
        logic [AW-1:0] nxt;
        @(negedge clk);
        rst = r; redirect_valid = rd; redirect_addr = ra; stall = st;
        call_valid = c; call_addr = ca; ret_valid = rt;
        e.ovf = 1'b0;
        e.unf = 1'b0;
        nxt = m_pc + AW'(1);
        if (r) begin
            m_pc = '0;
            m_ras.delete();
        end else if (rd) begin
            m_pc = ra;
        end else if (st) begin
            m_pc = m_pc;
        end else if (c && rt) begin
            if (m_ras.size() == 0) m_ras.push_back(nxt);
            else m_ras[m_ras.size()-1] = nxt;
            m_pc = ca;
        end else if (c) begin
            m_ras.push_back(nxt);
            if (m_ras.size() > DEPTH) begin
                void'(m_ras.pop_front());
                e.ovf = 1'b1;
            end
            m_pc = ca;
        end else if (rt) begin
            if (m_ras.size() == 0) begin
                m_pc = nxt;
                e.unf = 1'b1;
            end else begin
                m_pc = m_ras.pop_back();
            end
        end else begin
            m_pc = nxt;
        end
        e.pc = m_pc;
        e.cnt = m_ras.size();
        exp_q.push_back(e);
    endtask

    task automatic seq();    step(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic redir(input logic [AW-1:0] a); step(0, 1, a, 0, 0, 0, 0); endtask
    task automatic call(input logic [AW-1:0] a);  step(0, 0, 0, 0, 1, a, 0); endtask
    task automatic ret();    step(0, 0, 0, 0, 0, 0, 1); endtask

    initial begin
        int wait_cycles;
        m_pc = '0;
        step(1, 0, 0, 0, 0, 0, 0);
        repeat (4) seq();
        redir(13'h10);
        call(13'h100);
        seq(); seq();
        ret();
        redir(13'h20);
        call(13'h30); call(13'h40); call(13'h50); call(13'h60); call(13'h70);
        repeat (5) ret();
        call(13'h80);
        repeat (3) step(0, 0, 0, 1, 1, 13'h123, 0);
        step(0, 1, 13'h1ABC, 1, 1, 13'h55, 1);
        redir(13'h1FFF);
        seq();
        redir(13'h98);
        call(13'h40);
        step(0, 0, 0, 0, 1, 13'h200, 1);
        ret();
        call(13'h10); call(13'h20); call(13'h30);
        step(1, 1, 13'h777, 0, 1, 13'h5, 0);
        seq();
        for (int i = 0; i < 400; i++)
            step(($urandom_range(63) == 0), ($urandom_range(9) == 0), AW'($urandom),
                 ($urandom_range(5) == 0), ($urandom_range(3) == 0), AW'($urandom),
                 ($urandom_range(3) == 0));
        @(negedge clk);
        rst = 0; redirect_valid = 0; stall = 0; call_valid = 0; ret_valid = 0;
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the IF stage. It holds the fetch address and advances it sequentially by a fixed step. It supports stall, redirect (branch/mispredict recovery) and call/return through an internal circular return-address stack (RAS). Its output drives the instruction-memory address port and the IF/ID pipeline register.

## Interface
- ADDR_W, 13, fetch address width in bits.
- STEP, 1, sequential increment added to pc each advancing cycle.
- RESET_ADDR, 0, value loaded into pc on reset.
- RAS_DEPTH, 4, return-address stack entries; must be ≥1 (power of two not required).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold pc and RAS for this cycle.
- redirect_valid  in  1  load redirect_addr into pc.
- redirect_addr  in  ADDR_W  redirect target.
- call_valid  in  1  jump to call_addr and push return address.
- call_addr  in  ADDR_W  call target.
- ret_valid  in  1  pop RAS top into pc.
- pc  out  ADDR_W  current fetch address (registered).
- ras_count  out  $clog2(RAS_DEPTH+1)  valid RAS entries (registered).
- ras_overflow  out  1  one-cycle pulse: a push discarded the oldest entry.
- ras_underflow  out  1  one-cycle pulse: ret with empty RAS.

## Operation
- Priority per cycle, highest first: rst > redirect_valid > stall > call/ret > sequential.
- rst: pc=RESET_ADDR, ras_count=0, RAS write pointer=0, both pulses 0. RAS entry contents don't-care.
- redirect_valid=1: pc=redirect_addr. This applies even while stall=1; recovery must not be lost. call/ret are ignored and the RAS is untouched.
- stall=1 (no redirect): pc, RAS, pointer and count hold. call/ret are ignored and the pulses are 0.
- call_valid=1, ret_valid=0:
  - pc=call_addr.
  - Push pc+STEP.
  - If ras_count==RAS_DEPTH, the oldest entry is overwritten, ras_count stays RAS_DEPTH and ras_overflow=1.
  - Otherwise ras_count+1.
- ret_valid=1, call_valid=0:
  - ras_count>0: pc=top entry, ras_count−1.
  - ras_count==0: pc=pc+STEP and ras_underflow=1.
- call_valid=1 and ret_valid=1 (tail call):
  - pc=call_addr.
  - The top entry is replaced with pc+STEP.
  - ras_count is unchanged, but becomes 1 if it was 0.
  - No pulses.
- None of the above: pc=pc+STEP.
- Arithmetic: pc+STEP is truncated to ADDR_W bits (modulo 2^ADDR_W wrap, no flag).
- RAS is a circular buffer. The pointer wraps at RAS_DEPTH; after overflow, pops return the most recent RAS_DEPTH pushes in LIFO order.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Latency: control asserted in the cycle ending at edge N takes effect in pc at edge N (visible in the cycle after).
- Pulses are high for exactly the one cycle following the causing edge, and 0 otherwise.
- Reset mid-operation (e.g. during stall or with call asserted): the reset values win at that edge; inputs in the same cycle are ignored.
- pc is valid every cycle after the first reset edge. Before the first reset, outputs are undefined.

## Test plan
- Reset then 4 free-running cycles, STEP=1 → pc=0,1,2,3,4; ras_count=0.
- pc=0x10, call_valid with call_addr=0x100 → pc=0x100, ras_count=1. Two sequential cycles, then ret_valid → pc=0x11, ras_count=0.
- RAS_DEPTH=4: 5 nested calls from pc=0x20,0x30,0x40,0x50,0x60 → 5th call pulses ras_overflow, ras_count=4. Four rets → pc=0x61,0x51,0x41,0x31. 5th ret → ras_underflow=1, pc=0x32.
- stall=1 for 3 cycles with call_valid=1 → pc and ras_count unchanged, no pulses. stall=1 with redirect_valid=1, redirect_addr=0x1ABC → pc=0x1ABC.
- pc=0x1FFF, ADDR_W=13, sequential → pc=0x0000. Simultaneous call+ret at pc=0x40 with call_addr=0x200 and top=0x99 → pc=0x200, top=0x41, count unchanged.
- rst asserted while redirect_valid=1 and ras_count=3 → pc=RESET_ADDR, ras_count=0, pulses 0.
